alu_result_disp: RTL

Downstream consumer of the 4-bit ALU stage. It captures each ALU result with its opcode, operands and carry. It interprets the result according to the opcode (signed, hex or boolean) and drives a 4-digit multiplexed seven-segment display. Signed overflow is shown by blinking.

---
 rtl/alu_disp_pkg.sv | 57 +++++
 rtl/seg7_hex_decode.sv | 15 +
 rtl/alu_result_disp.sv | 136 +++++++++++++
 3 files changed

// File: rtl/alu_disp_pkg.sv
// Shared opcodes, glyph constants and helpers for the ALU result display.
// Glyphs are active-low segment patterns ordered g..a.
package alu_disp_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_EQ  = 3'b111;

    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
    localparam logic [6:0] GLYPH_MINUS = 7'b0111111;
    localparam logic [7:0] SEG_OFF     = 8'hFF;

    function automatic logic [6:0] hex_glyph(input logic [3:0] value);
        logic [6:0] g;
        case (value)
            4'h0:    g = 7'b1000000;
            4'h1:    g = 7'b1111001;
            4'h2:    g = 7'b0100100;
            4'h3:    g = 7'b0110000;
            4'h4:    g = 7'b0011001;
            4'h5:    g = 7'b0010010;
            4'h6:    g = 7'b0000010;
            4'h7:    g = 7'b1111000;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0010000;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b0000011;
            4'hC:    g = 7'b1000110;
            4'hD:    g = 7'b0100001;
            4'hE:    g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    // Two's complement overflow of the 4-bit add/sub; logic ops never overflow.
    function automatic logic signed_ovf(input logic [2:0] op, input logic [3:0] a,
                                        input logic [3:0] b, input logic [3:0] result);
        logic ovf;
        case (op)
            OP_ADD:  ovf = (a[3] == b[3]) && (result[3] != a[3]);
            OP_SUB:  ovf = (a[3] != b[3]) && (result[3] != a[3]);
            default: ovf = 1'b0;
        endcase
        return ovf;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational 4-bit value to active-low seven-segment glyph (g..a),
// forced to all-off when blank is high.
module seg7_hex_decode
    import alu_disp_pkg::*;
(
    input  logic [3:0] value,
    input  logic       blank,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = blank ? GLYPH_BLANK : hex_glyph(value);
    end

endmodule

// File: rtl/alu_result_disp.sv
// Captures ALU results and shows them on a 4-digit multiplexed seven-segment display.
// Optional macro ALU_DISP_CARRY_DP_EN lights digit0's dp for add/sub carry.
module alu_result_disp
    import alu_disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV   = 16,
    parameter int unsigned BLINK_HALF = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [2:0] op,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] result,
    input  logic       carry,
    output logic [7:0] seg,
    output logic [3:0] an,
    output logic       ovf_led
);

    localparam int unsigned SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BLINK_W = $clog2(2 * BLINK_HALF);
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(2 * BLINK_HALF - 1);
    localparam logic [BLINK_W-1:0] BLINK_MID  = BLINK_W'(BLINK_HALF);

    logic [2:0]         op_q;
    logic [3:0]         result_q;
    logic               carry_q;
    logic               ovf_q;
    logic               cap_valid_q;
    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [1:0]         idx_q, idx_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic [7:0]         seg_q, seg_d;
    logic [3:0]         an_q, an_d;

    logic       blink_off;
    logic [3:0] mag;
    logic [3:0] d0_val;
    logic [6:0] glyph0;
    logic [6:0] glyph1;
    logic [6:0] glyph3;
    logic       dp0;

    always_comb begin
        scan_cnt_d  = (scan_cnt_q == SCAN_LAST) ? '0 : scan_cnt_q + 1'b1;
        idx_d       = (scan_cnt_q == SCAN_LAST) ? idx_q + 2'd1 : idx_q;
        blink_cnt_d = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + 1'b1;
    end

    assign blink_off = ovf_q && (blink_cnt_q >= BLINK_MID);

    // Magnitude of a 4-bit two's complement value; 4'b1000 maps to 8.
    always_comb begin
        mag = result_q[3] ? (4'd0 - result_q) : result_q;
        case (op_q)
            OP_ADD, OP_SUB: d0_val = mag;
            OP_SLT, OP_EQ:  d0_val = {3'b000, result_q[0]};
            default:        d0_val = result_q;
        endcase
    end

    seg7_hex_decode u_dec_op (
        .value ({1'b0, op_q}),
        .blank (!cap_valid_q),
        .glyph (glyph3)
    );

    seg7_hex_decode u_dec_res (
        .value (d0_val),
        .blank (!cap_valid_q || blink_off),
        .glyph (glyph0)
    );

    always_comb begin
        if (cap_valid_q && is_arith(op_q) && result_q[3] && !blink_off) begin
            glyph1 = GLYPH_MINUS;
        end else begin
            glyph1 = GLYPH_BLANK;
        end
    end

`ifdef ALU_DISP_CARRY_DP_EN
    assign dp0 = !(cap_valid_q && is_arith(op_q) && carry_q && !blink_off);
`else
    logic unused_carry;
    assign unused_carry = carry_q;
    assign dp0 = 1'b1;
`endif

    // seg/an are built from the next scan index so both switch on the same edge.
    always_comb begin
        case (idx_d)
            2'd0:    seg_d = {dp0, glyph0};
            2'd1:    seg_d = {1'b1, glyph1};
            2'd2:    seg_d = {1'b1, GLYPH_BLANK};
            default: seg_d = {1'b1, glyph3};
        endcase
        an_d = ~(4'b0001 << idx_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q        <= OP_ADD;
            result_q    <= 4'd0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            cap_valid_q <= 1'b0;
            scan_cnt_q  <= '0;
            idx_q       <= 2'd0;
            blink_cnt_q <= '0;
            seg_q       <= SEG_OFF;
            an_q        <= 4'hF;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            if (in_valid) begin
                op_q        <= op;
                result_q    <= result;
                carry_q     <= carry;
                ovf_q       <= signed_ovf(op, a, b, result);
                cap_valid_q <= 1'b1;
            end
        end
    end

    assign seg     = seg_q;
    assign an      = an_q;
    assign ovf_led = ovf_q;

endmodule
